// File: rtl/regfile_param.sv
// regfile_param: parametrised 2-read/1-write register file with a self-clearing
// initialisation sweep, optional hardwired-zero entry 0 and optional write-to-read bypass.
//
// Parameters:
//   DATA_W   - register / data width
//   ADDR_W   - address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG - 1: entry 0 reads 0 and writes to it are dropped
//   BYPASS   - 1: a same-cycle write to a read address is forwarded to that read port
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset; restarts the clear sweep
//   CLR        synchronous clear request; restarts the clear sweep
//   WE3        write enable (ignored until INIT_DONE)
//   A1, A2     read addresses
//   A3, WD3    write address / data
//   RD1, RD2   combinational read data (0 while initialising)
//   INIT_DONE  array fully cleared and accepting writes
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              INIT_DONE
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CpLast = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic {StInit, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cp_q, cp_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Sequencer: sweep CP over every entry, then sit in ready until CLR or reset.
  always_comb begin
    state_d = state_q;
    cp_d    = cp_q;
    if (CLR) begin
      state_d = StInit;
      cp_d    = '0;
    end else if (state_q == StInit) begin
      if (cp_q == CpLast) begin
        state_d = StReady;
      end
      cp_d = cp_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StInit;
      cp_q    <= '0;
    end else begin
      state_q <= state_d;
      cp_q    <= cp_d;
    end
  end

  assign INIT_DONE = (state_q == StReady);

  // Single array write port shared by the clear sweep and functional writes.
  // A CLR on the same edge as a write wins, so the write is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = A3;
    mem_wdata = WD3;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = cp_q[ADDR_W-1:0];
      mem_wdata = '0;
    end else if (WE3 && !CLR && !(ZERO_REG && (A3 == '0))) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array: the sweep provides the known state.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports: later assignments override earlier ones, giving the priority
  // init-forcing > zero register > bypass > array.
  always_comb begin
    RD1 = mem_q[A1];
    if (BYPASS && WE3 && (A3 == A1)) begin
      RD1 = WD3;
    end
    if (ZERO_REG && (A1 == '0)) begin
      RD1 = '0;
    end
    if (state_q != StReady) begin
      RD1 = '0;
    end
  end

  always_comb begin
    RD2 = mem_q[A2];
    if (BYPASS && WE3 && (A3 == A2)) begin
      RD2 = WD3;
    end
    if (ZERO_REG && (A2 == '0)) begin
      RD2 = '0;
    end
    if (state_q != StReady) begin
      RD2 = '0;
    end
  end

endmodule
